// File: rtl/mux_pkg.sv
// Shared constants and types for the mux_16bit_chip slice.
package mux_pkg;

  localparam int          MUX_DEFAULT_WIDTH       = 16;
  localparam logic [15:0] MUX_DEFAULT_RESET_VALUE = 16'h0000;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } mux_sel_e;

endpackage

// File: rtl/mux_16bit_chip_if.sv
// Bus bundle for the two-input word mux: data inputs, select and selected output.
interface mux_16bit_chip_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic [WIDTH-1:0] out;

  modport master (output a, output b, output s, input  out);
  modport slave  (input  a, input  b, input  s, output out);

endinterface

// File: rtl/mux_1bit_chip.sv
// Single-bit 2:1 selector built purely from NAND gates.
module mux_1bit_chip (
  output logic out,
  input  logic a,
  input  logic b,
  input  logic s
);

  logic s_n;
  logic nand_a;
  logic nand_b;

  // Classic four-NAND mux: an inverter for s, two gating NANDs, one combining NAND.
  assign s_n    = ~(s & s);
  assign nand_a = ~(a & s_n);
  assign nand_b = ~(b & s);
  assign out    = ~(nand_a & nand_b);

endmodule

// File: rtl/mux_16bit_chip.sv
// Word-wide 2:1 mux from per-bit NAND selectors, with an optional output
// register enabled by defining MUX16_OUT_REG_EN.
module mux_16bit_chip
  import mux_pkg::*;
#(
  parameter int               WIDTH       = MUX_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(MUX_DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s
);

  logic [WIDTH-1:0] sel;

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    mux_1bit_chip u_bit (
      .out (sel[i]),
      .a   (a[i]),
      .b   (b[i]),
      .s   (s)
    );
  end

`ifdef MUX16_OUT_REG_EN
  // Reset is asynchronous so it wins over any update pending at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RESET_VALUE;
    end else begin
      out <= sel;
    end
  end
`else
  // No state here: clk, rst_n and RESET_VALUE stay on the port list only so
  // both builds share one interface.
  localparam logic [WIDTH-1:0] unused_reset_value = RESET_VALUE;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign out = sel;
`endif

endmodule

// File: tb/tb_mux_16bit_chip.sv
// Self-checking bench for mux_16bit_chip; follows the build's MUX16_OUT_REG_EN setting.
module tb_mux_16bit_chip;

  localparam int          W        = 16;
  localparam logic [W-1:0] RST_VAL = 16'h0000;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] expected;
  int           compared;
  int           mismatched;

  mux_16bit_chip_if #(.WIDTH(W)) bus ();

  mux_16bit_chip #(.WIDTH(W), .RESET_VALUE(RST_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (bus.out),
    .a     (bus.a),
    .b     (bus.b),
    .s     (bus.s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each output bit taken from b where s is 1, from a otherwise.
  function automatic logic [W-1:0] refSelect(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sel);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = sel ? y[i] : x[i];
    return r;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
    @(negedge clk);
    bus.a = na;
    bus.b = nb;
    bus.s = ns;
`ifdef MUX16_OUT_REG_EN
    @(posedge clk);
    #1;
    expected = rst_n ? refSelect(na, nb, ns) : RST_VAL;
`else
    #1;
    expected = refSelect(na, nb, ns);
`endif
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (bus.out === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: out=%h expected=%h", tag, bus.out, expected);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] walk;
    compared   = 0;
    mismatched = 0;

    rst_n = 1'b0;
    bus.a = 16'hC3C3;
    bus.b = 16'h3C3C;
    bus.s = 1'b1;
    #1;
`ifdef MUX16_OUT_REG_EN
    expected = RST_VAL;
`else
    expected = 16'h3C3C;
`endif
    checkOutput("reset_state");

    applyStimulus(16'hA5A5, 16'h5A5A, 1'b0);
    checkOutput("during_reset");

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h0000, 16'hFFFF, 1'b0);
    checkOutput("zero_vs_ones_s0");
    applyStimulus(16'h0000, 16'hFFFF, 1'b1);
    checkOutput("zero_vs_ones_s1");
    applyStimulus(16'h07E0, 16'hFFFF, 1'b0);
    checkOutput("pattern_s0");
    applyStimulus(16'h07E0, 16'hFFFF, 1'b1);
    checkOutput("pattern_s1");

    for (int i = 0; i < W; i++) begin
      walk = 16'h0001 << i;
      applyStimulus(walk, ~walk, i[0]);
      checkOutput($sformatf("walk_bit%0d", i));
    end

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      applyStimulus(ra, rb, 1'($urandom));
      checkOutput($sformatf("random_%0d", n));
    end

`ifdef MUX16_OUT_REG_EN
    // Mid-cycle select change must not reach out before the next rising edge.
    applyStimulus(16'hAAAA, 16'h5555, 1'b0);
    checkOutput("hold_before");
    #2;
    bus.s = 1'b1;
    #2;
    checkOutput("hold_between_edges");
    @(posedge clk);
    #1;
    expected = 16'h5555;
    checkOutput("hold_after_edge");

    applyStimulus(16'h0000, 16'hFFFF, 1'b1);
    checkOutput("pre_reset_ones");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expected = RST_VAL;
    checkOutput("async_reset");
    bus.a = 16'h1234;
    bus.s = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_hold_edge");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expected = 16'h1234;
    checkOutput("first_edge_after_reset");
`else
    // Combinational path ignores reset entirely.
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(16'h1234, 16'hFFFF, 1'b0);
    checkOutput("comb_reset_follow_a");
    applyStimulus(16'h1234, 16'hFEDC, 1'b1);
    checkOutput("comb_reset_follow_b");
    rst_n = 1'b1;
    applyStimulus(16'hBEEF, 16'h0F0F, 1'b0);
    checkOutput("comb_after_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_16bit_chip.md
MUX_16BIT_CHIP -- requirements
Module: mux_16bit_chip

Interface
REQ-001 Parameter WIDTH, default 16, data width of a, b and out; legal values 1..64.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits), value of out while the output register is reset.
REQ-003 Port clk, input, 1 bit, single clock; rising edge active.
REQ-004 Port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 Port out, output, WIDTH bits, selected data.
REQ-006 Port a, input, WIDTH bits, data selected when s=0.
REQ-007 Port b, input, WIDTH bits, data selected when s=1.
REQ-008 Port s, input, 1 bit, select.
REQ-009 Positional port order SHALL be clk, rst_n, out, a, b, s.

Function
REQ-010 Selection SHALL be bitwise for every bit i: out[i] = a[i] when s=0, b[i] when s=1.
REQ-011 No arithmetic, truncation or sign extension SHALL occur; all bits pass unchanged.
REQ-012 s=X/Z is not a legal input; no behaviour is defined for it.
REQ-013 With MUX16_OUT_REG_EN defined: out SHALL update on each rising clk edge with the selection from REQ-010, giving 1-cycle latency.
REQ-014 With MUX16_OUT_REG_EN defined: a, b or s changing between edges SHALL NOT affect out until the next edge.
REQ-015 Without MUX16_OUT_REG_EN: out SHALL be purely combinational with zero-cycle latency.
REQ-016 Without MUX16_OUT_REG_EN: clk and rst_n SHALL be unused and no state SHALL exist.
REQ-017 No handshake exists; every clk edge (registered mode) accepts new inputs.

Reset
REQ-018 Registered mode: rst_n=0 SHALL force out to RESET_VALUE immediately, without waiting for clk.
REQ-019 Registered mode: while rst_n=0, out SHALL hold RESET_VALUE regardless of inputs.
REQ-020 Registered mode: the first rising clk edge after rst_n deasserts SHALL load the selected data.
REQ-021 Registered mode: reset asserted mid-operation SHALL override any pending update.
REQ-022 Combinational mode: out SHALL follow the inputs during reset.

Configuration
REQ-023 Macro MUX16_OUT_REG_EN controls the output register.
REQ-024 When MUX16_OUT_REG_EN is defined, the output register is present (REQ-013, REQ-014, REQ-018..REQ-021 apply).
REQ-025 When MUX16_OUT_REG_EN is absent, the output register is removed (REQ-015, REQ-016, REQ-022 apply).
REQ-026 The port list SHALL be identical in both configurations.

Structure
REQ-027 Shared package mux_pkg SHALL hold the default width constant (16) and the default reset value constant (16'h0000).
REQ-028 The per-bit selector SHALL be sub-module mux_1bit_chip (out, a, b, s), built from NAND-level logic.
REQ-029 mux_16bit_chip SHALL instantiate WIDTH copies of mux_1bit_chip through a generate loop.
REQ-030 The optional output register SHALL sit after the generate loop.

Verification (run each in both configurations; registered mode checks out one edge later)
REQ-031 a=16'h0000, b=16'hFFFF, s=0 -> out=16'h0000.
REQ-032 a=16'h0000, b=16'hFFFF, s=1 -> out=16'hFFFF.
REQ-033 a=16'h07E0, b=16'hFFFF, s=0 -> out=16'h07E0; then s=1 -> out=16'hFFFF.
REQ-034 Walk a single 1 across a, with b=~a, s toggling -> every bit matches REQ-010.
REQ-035 Registered mode: out=16'hFFFF, assert rst_n=0 between edges -> out=16'h0000 immediately; after release, the first edge with a=16'h1234, s=0 -> out=16'h1234.
REQ-036 Registered mode: change s between edges -> out unchanged until the next rising edge.
